// File: rtl/op_scheduler.sv
// Command FIFO and one-at-a-time sequencer in front of the FHE op controller.
// Optional watchdog on the RUN wait is enabled by defining SCHED_TIMEOUT_EN.
module op_scheduler #(
  parameter int ADDR_WIDTH     = 10,
  parameter int BIG_N          = 30,
  parameter int TAG_WIDTH      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int PTR_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
  input  logic [BIG_N-1:0]      cmd_noise,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  ctl_config_en,
  output logic [1:0]            ctl_opcode,
  output logic [ADDR_WIDTH-1:0] ctl_op1_base_addr,
  output logic [ADDR_WIDTH-1:0] ctl_op2_base_addr,
  output logic [ADDR_WIDTH-1:0] ctl_out_base_addr,
  output logic [BIG_N-1:0]      ctl_noise,
  input  logic                  ctl_done,
  output logic                  cpl_valid,
  output logic [TAG_WIDTH-1:0]  cpl_tag,
  output logic                  cpl_error,
  output logic                  busy,
  output logic [PTR_WIDTH:0]    fifo_count
);

  localparam int ENTRY_W = 2 + 3 * ADDR_WIDTH + BIG_N + TAG_WIDTH;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [PTR_WIDTH:0]   CNT_ONE = 1;
  localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SETTLE,
    S_RUN,
    S_CPL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [PTR_WIDTH:0]   r_count;
  logic [TAG_WIDTH-1:0] r_run_tag;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_timeout;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push     = cmd_valid && !w_full;
  assign w_wr_entry = {cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr,
                       cmd_noise, cmd_tag};
  assign w_rd_entry = r_mem[r_rd_ptr];

  // Storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_CONFIG;
        end
      end
      S_CONFIG: w_state_nxt = S_SETTLE;
      // The controller's stale done may still be visible here.
      S_SETTLE: w_state_nxt = S_RUN;
      S_RUN: begin
        if (ctl_done || w_timeout) begin
          w_state_nxt = S_CPL;
        end
      end
      S_CPL: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_CONFIG;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command fields stay stable from one pop to the next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_opcode        <= '0;
      ctl_op1_base_addr <= '0;
      ctl_op2_base_addr <= '0;
      ctl_out_base_addr <= '0;
      ctl_noise         <= '0;
      r_run_tag         <= '0;
    end else if (w_pop) begin
      {ctl_opcode, ctl_op1_base_addr, ctl_op2_base_addr, ctl_out_base_addr,
       ctl_noise, r_run_tag} <= w_rd_entry;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE  = 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  // Expires on the edge at which the count would reach TIMEOUT_CYCLES.
  assign w_timeout = (r_wdog == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_SETTLE) begin
        r_wdog <= '0;
      end else if (r_state == S_RUN && !ctl_done) begin
        r_wdog <= r_wdog + WD_ONE;
      end
      r_err <= (r_state == S_RUN) && !ctl_done && w_timeout;
    end
  end

  assign cpl_error = (r_state == S_CPL) && r_err;
`else
  // No watchdog: RUN waits for done indefinitely; the parameter stays referenced.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign cpl_error = 1'b0;
`endif

  assign cmd_ready     = !w_full;
  assign ctl_config_en = (r_state == S_CONFIG);
  assign cpl_valid     = (r_state == S_CPL);
  assign cpl_tag       = r_run_tag;
  assign busy          = (r_state != S_IDLE) || !w_empty;
  assign fifo_count    = r_count;

endmodule

// File: tb/tb_op_scheduler.sv
// Scoreboard bench for op_scheduler with a behavioural controller model.
// Runs the watchdog scenario only when SCHED_TIMEOUT_EN is defined.
module tb_op_scheduler;

  localparam int AW = 10;
  localparam int BN = 30;
  localparam int TW = 4;
  localparam int FD = 4;
  localparam int PW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode;
  logic [AW-1:0] cmd_op1_addr, cmd_op2_addr, cmd_out_addr;
  logic [BN-1:0] cmd_noise;
  logic [TW-1:0] cmd_tag;
  logic          ctl_config_en;
  logic [1:0]    ctl_opcode;
  logic [AW-1:0] ctl_op1_base_addr, ctl_op2_base_addr, ctl_out_base_addr;
  logic [BN-1:0] ctl_noise;
  logic          ctl_done;
  logic          cpl_valid;
  logic [TW-1:0] cpl_tag;
  logic          cpl_error;
  logic          busy;
  logic [PW:0]   fifo_count;

  always #5 clk = ~clk;

  op_scheduler #(
    .ADDR_WIDTH(AW), .BIG_N(BN), .TAG_WIDTH(TW), .FIFO_DEPTH(FD),
    .PTR_WIDTH(PW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_op1_addr(cmd_op1_addr), .cmd_op2_addr(cmd_op2_addr),
    .cmd_out_addr(cmd_out_addr), .cmd_noise(cmd_noise), .cmd_tag(cmd_tag),
    .ctl_config_en(ctl_config_en), .ctl_opcode(ctl_opcode),
    .ctl_op1_base_addr(ctl_op1_base_addr), .ctl_op2_base_addr(ctl_op2_base_addr),
    .ctl_out_base_addr(ctl_out_base_addr), .ctl_noise(ctl_noise),
    .ctl_done(ctl_done), .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .cpl_error(cpl_error), .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] a1, a2, ao;
    logic [BN-1:0] nz;
    logic [TW-1:0] tag;
    logic          err;
    int            dly;
  } cmd_t;

  cmd_t cfg_q[$];
  cmd_t cpl_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cpl_seen = 0;
  int cfg_cyc = 0;
  int cur_delay = 0;
  int b2b_cyc = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: done rises dly cycles after the config edge (dly==0: never),
  // and a stale done lingers one extra cycle past config so SETTLE sees it.
  int   m_cnt;
  logic m_clr;
  always @(posedge clk) begin
    if (!rst_n) begin
      ctl_done <= 1'b0;
      m_cnt    <= 0;
      m_clr    <= 1'b0;
    end else if (ctl_config_en) begin
      m_clr <= 1'b1;
      m_cnt <= cur_delay;
    end else begin
      if (m_clr) begin
        m_clr    <= 1'b0;
        ctl_done <= 1'b0;
      end
      if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt    <= 0;
        ctl_done <= 1'b1;
      end
    end
  end

  // Monitor: pops expectations on each config pulse and each completion.
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (b2b_cyc == cyc) check("b2b_config", ctl_config_en, 1);
        if (ctl_config_en) begin
          check("cfg_expected", cfg_q.size() != 0, 1);
          if (cfg_q.size() != 0) begin
            c = cfg_q.pop_front();
            check("cfg_opcode", ctl_opcode, c.op);
            check("cfg_op1", ctl_op1_base_addr, c.a1);
            check("cfg_op2", ctl_op2_base_addr, c.a2);
            check("cfg_out", ctl_out_base_addr, c.ao);
            check("cfg_noise", ctl_noise, c.nz);
            cfg_cyc   = cyc;
            cur_delay = c.dly;
          end
        end
        if (cpl_valid) begin
          cpl_seen++;
          check("cpl_expected", cpl_q.size() != 0, 1);
          if (cpl_q.size() != 0) begin
            c = cpl_q.pop_front();
            check("cpl_tag", cpl_tag, c.tag);
            check("cpl_error", cpl_error, c.err);
            check("cpl_latency", cyc - cfg_cyc, (c.dly == 0) ? TO + 2 : c.dly + 2);
          end
          if (cfg_q.size() != 0) b2b_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [AW-1:0] a1, a2, ao,
                      input logic [BN-1:0] nz, input logic [TW-1:0] tag,
                      input int dly, input logic err);
    cmd_t c;
    int   n;
    logic acc;
    c.op = op; c.a1 = a1; c.a2 = a2; c.ao = ao; c.nz = nz;
    c.tag = tag; c.dly = dly; c.err = err;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_op1_addr = a1; cmd_op2_addr = a2;
    cmd_out_addr = ao; cmd_noise = nz; cmd_tag = tag;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      acc = cmd_ready;
      if (acc) begin
        cfg_q.push_back(c);
        cpl_q.push_back(c);
      end
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("push_accept", acc, 1);
  endtask

  task automatic push_t(input logic [TW-1:0] tag, input int dly, input logic err);
    push(tag[1:0], AW'(16 * tag + 1), AW'(16 * tag + 2), AW'(16 * tag + 3),
         BN'(32'h1000 * tag + 32'h5), tag, dly, err);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || cpl_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", busy || cpl_q.size() != 0, 0);
  endtask

  task automatic check_reset();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_config_en", ctl_config_en, 0);
    check("rst_opcode", ctl_opcode, 0);
    check("rst_op1", ctl_op1_base_addr, 0);
    check("rst_op2", ctl_op2_base_addr, 0);
    check("rst_out", ctl_out_base_addr, 0);
    check("rst_noise", ctl_noise, 0);
    check("rst_cpl_valid", cpl_valid, 0);
    check("rst_cpl_tag", cpl_tag, 0);
    check("rst_cpl_error", cpl_error, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
  endtask

  initial begin
    int n, seen0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_op1_addr = '0;
    cmd_op2_addr = '0; cmd_out_addr = '0; cmd_noise = '0; cmd_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ENCRYPT, checking idle-to-config latency.
    push(2'd0, 10'h010, 10'h020, 10'h100, 30'h5A5A5, 4'd3, 12, 1'b0);
    @(negedge clk);
    check("idle_pop_cycle", ctl_config_en, 0);
    @(negedge clk);
    check("config_cycle", ctl_config_en, 1);
    wait_idle(100);

    // Five commands against a slow controller fill the FIFO.
    for (int i = 0; i < 5; i++) push_t(TW'(i), 20, 1'b0);
    check("full_ready", cmd_ready, 0);
    check("full_count", fifo_count, 4);
    wait_idle(400);

    // Second op starts while done is still high from the first.
    push_t(4'd5, 4, 1'b0);
    wait_idle(100);
    push_t(4'd6, 9, 1'b0);
    wait_idle(100);

    // Push during the CPL pop at fifo_count=2.
    push_t(4'd7, 6, 1'b0);
    push_t(4'd8, 6, 1'b0);
    push_t(4'd9, 6, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpl_valid && n < 100);
    check("pushpop_cpl", cpl_valid, 1);
    check("pushpop_pre", fifo_count, 2);
    push_t(4'd10, 6, 1'b0);
    check("pushpop_count", fifo_count, 2);
    wait_idle(200);

    // Reset while RUN with two commands queued.
    push_t(4'd11, 30, 1'b0);
    push_t(4'd12, 30, 1'b0);
    push_t(4'd13, 30, 1'b0);
    check("prerst_count", fifo_count, 2);
    repeat (4) @(posedge clk);
    #1;
    check("prerst_busy", busy, 1);
    rst_n = 1'b0;
    cfg_q.delete();
    cpl_q.delete();
    b2b_cyc = -1;
    @(posedge clk); #1;
    check_reset();
    rst_n = 1'b1;
    seen0 = cpl_seen;
    repeat (40) @(posedge clk);
    #1;
    check("postrst_no_cpl", cpl_seen - seen0, 0);
    check("postrst_busy", busy, 0);

    push_t(4'd14, 3, 1'b0);
    wait_idle(100);

`ifdef SCHED_TIMEOUT_EN
    // Controller never finishes; the watchdog aborts and the next command runs.
    push_t(4'd1, 0, 1'b1);
    push_t(4'd2, 5, 1'b0);
    wait_idle(100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
